// File: rtl/tp_cmd_pkg.sv
// Shared types and constants for the test-point command receiver.
// Holds the FSM state encoding, command codes, frame field widths and the injection decode.
package tp_cmd_pkg;

    localparam int DATA_W = 4;
    localparam int ERR_W  = 8;
    localparam int CNT_W  = 8;

    localparam logic [DATA_W-1:0] CMD_L1A     = 4'd1;
    localparam logic [DATA_W-1:0] CMD_LCT     = 4'd2;
    localparam logic [DATA_W-1:0] CMD_RESYNC  = 4'd3;
    localparam logic [DATA_W-1:0] CMD_SYS_RST = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    typedef struct packed {
        logic sys_rst;
        logic resync;
        logic lct;
        logic l1a;
    } inj_t;

    function automatic inj_t inj_decode(input logic [DATA_W-1:0] code);
        inj_t inj;
        inj = '0;
        case (code)
            CMD_L1A:     inj.l1a     = 1'b1;
            CMD_LCT:     inj.lct     = 1'b1;
            CMD_RESYNC:  inj.resync  = 1'b1;
            CMD_SYS_RST: inj.sys_rst = 1'b1;
            default:     inj         = '0;
        endcase
        return inj;
    endfunction

endpackage

// File: rtl/tp_in_filter.sv
// Two-flop synchronizer followed by a glitch filter for one test-point pad.
// The filtered level flips only after FILT_LEN consecutive synchronized samples disagree with it.
module tp_in_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic filt_o
);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == 3'(FILT_LEN - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pad_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = level_q;

endmodule

// File: rtl/tp_cmd_rx.sv
// Serial command receiver on the test-point pads: start, 4 data LSB first, even parity, stop.
// state  | meaning
// IDLE   | waiting for a filtered falling edge on data with gate high and enabled
// START  | half-bit wait, confirm start bit still low
// DATA   | sample 4 data bits, one per bit period
// PARITY | sample parity bit
// STOP   | sample stop bit, emit command or frame error
module tp_cmd_rx
    import tp_cmd_pkg::*;
#(
    parameter int BIT_CYCLES = 8,
    parameter int FILT_LEN   = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [1:0]        tp_in_i,
    output logic              cmd_valid_o,
    output logic [DATA_W-1:0] cmd_code_o,
    output logic              inj_l1a_o,
    output logic              inj_lct_o,
    output logic              inj_resync_o,
    output logic              inj_sys_rst_o,
    output logic              frame_err_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic              busy_o
);

    // The counter samples on reaching zero, so a reload of BIT_CYCLES-1 spaces samples BIT_CYCLES apart.
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(BIT_CYCLES - 1);

    logic [1:0]        tp_filt;
    logic              data_filt, gate_filt, data_fall;
    logic              data_prev_q;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] code_q, code_d;
    inj_t              inj_q, inj_d;
    logic              ferr_q, ferr_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              tick;

    for (genvar i = 0; i < 2; i++) begin : g_filt
        tp_in_filter #(.FILT_LEN(FILT_LEN)) u_filt (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .pad_i  (tp_in_i[i]),
            .filt_o (tp_filt[i])
        );
    end

    assign data_filt = tp_filt[0];
    assign gate_filt = tp_filt[1];
    assign data_fall = data_prev_q & ~data_filt;
    assign tick      = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? cnt_q : cnt_q - 8'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        valid_d   = 1'b0;
        code_d    = code_q;
        inj_d     = '0;
        ferr_d    = 1'b0;
        err_cnt_d = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i && gate_filt && data_fall) begin
                    state_d = ST_START;
                    cnt_d   = HALF_BIT;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (!data_filt) begin
                        state_d = ST_DATA;
                        cnt_d   = RELOAD;
                        bit_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {data_filt, shift_q[DATA_W-1:1]};
                    cnt_d   = RELOAD;
                    if (bit_q == 2'(DATA_W - 1)) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_d = bit_q + 2'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    par_d   = data_filt;
                    cnt_d   = RELOAD;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    if (data_filt && !(^{shift_q, par_q})) begin
                        valid_d = 1'b1;
                        code_d  = shift_q;
                        inj_d   = inj_decode(shift_q);
                    end else begin
                        ferr_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides any sample taken in the same cycle.
        if (state_q != ST_IDLE && (!enable_i || !gate_filt)) begin
            state_d   = ST_IDLE;
            valid_d   = 1'b0;
            code_d    = code_q;
            inj_d     = '0;
            ferr_d    = 1'b0;
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            data_prev_q <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            valid_q     <= 1'b0;
            code_q      <= '0;
            inj_q       <= '0;
            ferr_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            data_prev_q <= data_filt;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            inj_q       <= inj_d;
            ferr_q      <= ferr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_valid_o   = valid_q;
    assign cmd_code_o    = code_q;
    assign inj_l1a_o     = inj_q.l1a;
    assign inj_lct_o     = inj_q.lct;
    assign inj_resync_o  = inj_q.resync;
    assign inj_sys_rst_o = inj_q.sys_rst;
    assign frame_err_o   = ferr_q;
    assign err_cnt_o     = err_cnt_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tp_cmd_rx.sv
// Directed bench for tp_cmd_rx: frames drive a scoreboard of expected outputs,
// a negedge monitor pops and compares every output pulse.
module tb_tp_cmd_rx;

    localparam int BIT  = 8;
    localparam int NONE = 99;

    typedef struct {
        logic       err;
        logic [3:0] code;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] tp_in;
    logic       cmd_valid, frame_err, busy;
    logic [3:0] cmd_code;
    logic       inj_l1a, inj_lct, inj_resync, inj_sys_rst;
    logic [7:0] err_cnt;
    logic [3:0] inj;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_valid = 0, n_ferr = 0;
    int   n_inj[4] = '{0, 0, 0, 0};
    logic busy_seen;

    assign inj = {inj_sys_rst, inj_resync, inj_lct, inj_l1a};

    tp_cmd_rx #(.BIT_CYCLES(BIT), .FILT_LEN(3)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .tp_in_i       (tp_in),
        .cmd_valid_o   (cmd_valid),
        .cmd_code_o    (cmd_code),
        .inj_l1a_o     (inj_l1a),
        .inj_lct_o     (inj_lct),
        .inj_resync_o  (inj_resync),
        .inj_sys_rst_o (inj_sys_rst),
        .frame_err_o   (frame_err),
        .err_cnt_o     (err_cnt),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_inj(input logic [3:0] code);
        case (code)
            4'd1:    return 4'b0001;
            4'd2:    return 4'b0010;
            4'd3:    return 4'b0100;
            4'd4:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic err, input logic [3:0] code);
        exp_t e;
        e.err  = err;
        e.code = code;
        sb_q.push_back(e);
    endtask

    // bits[0] start, bits[4:1] data LSB first, bits[5] parity, bits[6] stop
    task automatic send_frame(input logic [3:0] code, input logic flip, input logic stop,
                              input int abort_bit, input int rst_bit);
        logic [6:0] bits;
        bits = {stop, (^code) ^ flip, code, 1'b0};
        for (int i = 0; i < 7; i++) begin
            tp_in[0] = bits[i];
            if (i == abort_bit) begin
                check("busy_before_abort", busy, 1);
                tp_in[1] = 1'b0;
                cycles(7);
                check("busy_after_abort", busy, 0);
                cycles(1);
            end else if (i == rst_bit) begin
                cycles(4);
                check("busy_before_rst", busy, 1);
                rst = 1'b1;
                #1;
                check("rst_outputs_zero", {cmd_valid, frame_err, inj, cmd_code, err_cnt, busy}, 0);
                cycles(2);
                rst = 1'b0;
                cycles(2);
            end else begin
                cycles(BIT);
            end
        end
        tp_in[0] = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) n_valid++;
            if (frame_err) n_ferr++;
            for (int k = 0; k < 4; k++) if (inj[k]) n_inj[k]++;
            if (cmd_valid || frame_err || inj != 4'b0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", {cmd_valid, frame_err, inj}, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_cmd_valid", cmd_valid, !mon_e.err);
                    check("sb_frame_err", frame_err, mon_e.err);
                    check("sb_inj", inj, mon_e.err ? 4'b0 : exp_inj(mon_e.code));
                    if (!mon_e.err) check("sb_cmd_code", cmd_code, mon_e.code);
                end
            end
        end
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        tp_in  = 2'b11;
        cycles(3);
        check("reset_valid", cmd_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_inj", inj, 0);
        check("reset_code", cmd_code, 0);
        check("reset_err_cnt", err_cnt, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        cycles(10);

        // code 3 frame
        push(1'b0, 4'd3);
        send_frame(4'd3, 1'b0, 1'b1, NONE, NONE);
        cycles(10);
        check("c3_code", cmd_code, 3);
        check("c3_err_cnt", err_cnt, 0);
        check("c3_n_valid", n_valid, 1);
        check("c3_n_resync", n_inj[2], 1);

        // gate dropped during DATA of a code-2 frame
        send_frame(4'd2, 1'b0, 1'b1, 2, NONE);
        tp_in[1] = 1'b1;
        cycles(12);
        check("abort_n_lct", n_inj[1], 0);
        check("abort_err_cnt", err_cnt, 0);
        check("abort_code_held", cmd_code, 3);

        // 2-cycle glitch must not leave IDLE
        tp_in[0] = 1'b0;
        cycles(2);
        tp_in[0] = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycles(1);
            busy_seen |= busy;
        end
        check("glitch_busy", busy_seen, 0);

        // 5-cycle low: enters START then false start
        tp_in[0] = 1'b0;
        cycles(5);
        tp_in[0] = 1'b1;
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            busy_seen |= busy;
        end
        check("false_start_busy_seen", busy_seen, 1);
        check("false_start_idle", busy, 0);
        check("false_start_err_cnt", err_cnt, 0);

        // receiver disabled: frame ignored
        enable = 1'b0;
        send_frame(4'd1, 1'b0, 1'b1, NONE, NONE);
        cycles(10);
        enable = 1'b1;
        cycles(5);
        check("disabled_n_l1a", n_inj[0], 0);
        check("disabled_busy", busy, 0);

        // parity error on code 1
        push(1'b1, 4'd1);
        send_frame(4'd1, 1'b1, 1'b1, NONE, NONE);
        cycles(10);
        check("perr_err_cnt", err_cnt, 1);
        check("perr_n_l1a", n_inj[0], 0);
        check("perr_n_ferr", n_ferr, 1);
        check("perr_code_held", cmd_code, 3);

        // stop error
        push(1'b1, 4'd5);
        send_frame(4'd5, 1'b0, 1'b0, NONE, NONE);
        cycles(10);
        check("stoperr_err_cnt", err_cnt, 2);

        // 300 more parity errors saturate the counter
        for (int i = 0; i < 300; i++) begin
            push(1'b1, 4'd1);
            send_frame(4'd1, 1'b1, 1'b1, NONE, NONE);
        end
        cycles(10);
        check("sat_err_cnt", err_cnt, 255);
        check("sat_n_ferr", n_ferr, 302);
        check("sat_n_l1a", n_inj[0], 0);

        // reset during PARITY of a code-4 frame
        send_frame(4'd4, 1'b0, 1'b1, NONE, 5);
        cycles(10);
        check("rst_n_sysrst", n_inj[3], 0);
        check("rst_code", cmd_code, 0);
        check("rst_err_cnt", err_cnt, 0);
        push(1'b0, 4'd4);
        send_frame(4'd4, 1'b0, 1'b1, NONE, NONE);
        cycles(10);
        check("c4_n_sysrst", n_inj[3], 1);
        check("c4_code", cmd_code, 4);

        // back-to-back codes 7 then 2
        push(1'b0, 4'd7);
        push(1'b0, 4'd2);
        send_frame(4'd7, 1'b0, 1'b1, NONE, NONE);
        send_frame(4'd2, 1'b0, 1'b1, NONE, NONE);
        cycles(10);
        check("b2b_n_valid", n_valid, 4);
        check("b2b_n_lct", n_inj[1], 1);
        check("b2b_n_l1a", n_inj[0], 0);
        check("b2b_n_resync", n_inj[2], 1);
        check("b2b_code", cmd_code, 2);
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tp_cmd_rx.md
TP_CMD_RX -- requirements
Module: tp_cmd_rx

Interface
REQ-001 The block SHALL have parameter BIT_CYCLES, default 8, giving CLK cycles per serial bit; legal range 4..255.
REQ-002 The block SHALL have parameter FILT_LEN, default 3, giving consecutive equal samples needed to change the filtered level; legal range 1..7.
REQ-003 CLK  input  1  system clock; all logic in this single domain.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 ENABLE  input  1  receiver enable; low forces IDLE.
REQ-006 TP_IN  input  2  raw test-point pad levels from the tri-stated IOBUF outputs. Bit 0 is serial data, idle high. Bit 1 is the arm gate, high to accept frames.
REQ-007 CMD_VALID  output  1  one-cycle pulse per good frame.
REQ-008 CMD_CODE  output  4  last good command code; holds between frames.
REQ-009 INJ_L1A, INJ_LCT, INJ_RESYNC, INJ_SYS_RST  output  1 each  one-cycle injection pulses.
REQ-010 FRAME_ERR  output  1  one-cycle pulse on a parity or stop error.
REQ-011 ERR_CNT  output  8  count of frame errors.
REQ-012 BUSY  output  1  high in any state other than IDLE.

Function
REQ-013 Both TP_IN bits SHALL pass a 2-FF synchronizer and then a glitch filter. The filtered level changes only after FILT_LEN consecutive equal synchronized samples differ from it; filter resets to 1.
REQ-014 Frame format: start bit 0, then 4 data bits LSB first, then an even-parity bit (total ones over data plus parity even), then stop bit 1.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE->START on a filtered-data falling edge while ENABLE=1 and filtered gate=1; the bit counter loads BIT_CYCLES/2.
REQ-017 In START at mid-bit: data=0 -> DATA with counter reload BIT_CYCLES; data=1 -> false start, back to IDLE, no error.
REQ-018 Each later bit SHALL be sampled once, BIT_CYCLES cycles after the previous sample. DATA exits after 4 samples to PARITY, then STOP.
REQ-019 STOP sample: stop=1 and parity good -> CMD_VALID=1 and CMD_CODE updated in the next cycle, then IDLE. Otherwise -> FRAME_ERR=1 in the next cycle, then IDLE.
REQ-020 Decode on CMD_VALID cycle: code 1 -> INJ_L1A, 2 -> INJ_LCT, 3 -> INJ_RESYNC, 4 -> INJ_SYS_RST. All other codes give CMD_VALID only, with no injection pulse.
REQ-021 At most one INJ_* output SHALL be high in any cycle; pulses are exactly 1 cycle wide.
REQ-022 ERR_CNT SHALL increment by 1 on each FRAME_ERR and saturate at 255 (no wrap).
REQ-023 Gate falling or ENABLE=0 in any non-IDLE state SHALL abort to IDLE next cycle, with no CMD_VALID, FRAME_ERR or INJ_* pulse.
REQ-024 A new start edge SHALL only be recognized once back in IDLE; a line low persisting from STOP does not retrigger until it returns high.
REQ-025 Latency: pad edge to filtered edge = 2+FILT_LEN cycles; stop mid-sample to outputs = 1 cycle.

Reset
REQ-026 RST SHALL asynchronously force the state to IDLE. All pulse outputs=0, CMD_CODE=0, ERR_CNT=0, BUSY=0, synchronizers and filters=1, counters=0.
REQ-027 RST asserted mid-frame SHALL discard the frame with no output pulse after release.

Structure
REQ-028 Package tp_cmd_pkg SHALL hold the state enumeration, the command-code constants (CMD_L1A=1, CMD_LCT=2, CMD_RESYNC=3, CMD_SYS_RST=4) and the frame field widths.
REQ-029 The synchronizer plus glitch filter SHALL be sub-module tp_in_filter, instantiated once per TP_IN bit.

Verification
REQ-030 Send frame code 3 (data 1,1,0,0, parity 0, stop 1) at BIT_CYCLES=8 with gate high -> one CMD_VALID, CMD_CODE=3, one INJ_RESYNC pulse, ERR_CNT=0.
REQ-031 Send code 1 with parity bit flipped to 0 -> FRAME_ERR once, ERR_CNT=1, no CMD_VALID, no INJ_L1A; repeat 300 times -> ERR_CNT=255.
REQ-032 Inject 2-cycle low glitches on data with FILT_LEN=3 -> BUSY stays 0, no outputs. Inject a 5-cycle low -> START entered, false start, no error.
REQ-033 Drop the gate during DATA of a code-2 frame -> IDLE within 1 cycle, no INJ_LCT, ERR_CNT unchanged.
REQ-034 Assert RST during PARITY of a code-4 frame -> all outputs 0 immediately; after release no INJ_SYS_RST; next code-4 frame produces one INJ_SYS_RST.
REQ-035 Send back-to-back frames for codes 7 then 2 -> CMD_VALID twice, CMD_CODE 7 then 2, only INJ_LCT pulses.
